// File: rtl/tlc_pkg.sv
// tlc_pkg: shared state, phase, light and selector encodings for the traffic light controller
package tlc_pkg;
    typedef enum logic [2:0] {MG = 3'd0, MY = 3'd1, WALK = 3'd2, SG = 3'd3, SGX = 3'd4, SY = 3'd5} state_t;
    typedef enum logic [1:0] {LOAD = 2'd0, GUARD = 2'd1, WAIT = 2'd2} phase_t;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT = 2'b01;
    localparam logic [1:0] SEL_YEL = 2'b10;
endpackage

// File: rtl/timing_param_regs.sv
// timing_param_regs: run-time programmable durations; zero is stored as one since the timer wraps on zero
module timing_param_regs
    import tlc_pkg::*;
#(
    parameter logic [3:0] T_BASE_DEF = 4'd6,
    parameter logic [3:0] T_EXT_DEF = 4'd3,
    parameter logic [3:0] T_YEL_DEF = 4'd2
) (
    input  logic       clock,
    input  logic       reset_sync_n,
    input  logic       prog_sync,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    output logic [3:0] t_base,
    output logic [3:0] t_ext,
    output logic [3:0] t_yel
);
    logic [3:0] clamped;
    assign clamped = time_value == 4'd0 ? 4'd1 : time_value;
    always_ff @(posedge clock or negedge reset_sync_n)
        if (!reset_sync_n) begin
            t_base <= T_BASE_DEF;
            t_ext <= T_EXT_DEF;
            t_yel <= T_YEL_DEF;
        end else if (prog_sync) begin
            if (time_param_sel == SEL_BASE) t_base <= clamped;
            if (time_param_sel == SEL_EXT) t_ext <= clamped;
            if (time_param_sel == SEL_YEL) t_yel <= clamped;
        end
endmodule

// File: rtl/traffic_light_controller.sv
// traffic_light_controller: light-sequencing FSM that loads the countdown timer on every state entry
module traffic_light_controller
    import tlc_pkg::*;
#(
    parameter logic [3:0] T_BASE_DEF = 4'd6,
    parameter logic [3:0] T_EXT_DEF = 4'd3,
    parameter logic [3:0] T_YEL_DEF = 4'd2
) (
    input  logic       clock,
    input  logic       reset_sync_n,
    input  logic       sensor,
    input  logic       walk_push,
    input  logic       prog_sync,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    input  logic       expired,
    output logic       start_timer,
    output logic [3:0] value,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk_light
);
    logic [3:0] t_base, t_ext, t_yel, dur;
    state_t state, nxt;
    phase_t phase;
    logic ext, walk_pend, go;

    timing_param_regs #(.T_BASE_DEF(T_BASE_DEF), .T_EXT_DEF(T_EXT_DEF), .T_YEL_DEF(T_YEL_DEF)) u_regs (
        .clock(clock),
        .reset_sync_n(reset_sync_n),
        .prog_sync(prog_sync),
        .time_param_sel(time_param_sel),
        .time_value(time_value),
        .t_base(t_base),
        .t_ext(t_ext),
        .t_yel(t_yel)
    );

    assign go = phase == WAIT && expired;
    assign dur = state == MG ? (ext ? t_ext : t_base) :
                 state == SG ? t_base :
                 (state == SGX || state == WALK) ? t_ext : t_yel;

    always_comb begin
        nxt = MG;
        case (state)
            MG:      nxt = (walk_pend || sensor) ? MY : MG;
            MY:      nxt = walk_pend ? WALK : SG;
            WALK:    nxt = SG;
            SG:      nxt = sensor ? SGX : SY;
            SGX:     nxt = SY;
            default: nxt = MG;
        endcase
    end

    // expired only counts in WAIT, so power-up and stale timer pulses are masked
    always_ff @(posedge clock or negedge reset_sync_n)
        if (!reset_sync_n) begin
            state <= MG;
            phase <= LOAD;
            ext <= 1'b0;
            walk_pend <= 1'b0;
            start_timer <= 1'b0;
            value <= T_BASE_DEF;
            main_lights <= RED;
            side_lights <= RED;
            walk_light <= 1'b0;
        end else begin
            start_timer <= phase == LOAD;
            walk_pend <= walk_push || (walk_pend && !(go && nxt == WALK));
            if (phase == LOAD) begin
                value <= dur;
                main_lights <= state == MG ? GRN : state == MY ? YEL : RED;
                side_lights <= (state == SG || state == SGX) ? GRN : state == SY ? YEL : RED;
                walk_light <= state == WALK;
                phase <= GUARD;
            end else if (phase == GUARD) begin
                phase <= WAIT;
            end else if (expired) begin
                state <= nxt;
                phase <= LOAD;
                ext <= state == MG && nxt == MG;
            end
        end
endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller: scenario bench with a scoreboard of expected timer loads
module tb_traffic_light_controller;
    import tlc_pkg::*;

    logic clock = 1'b0;
    logic reset_sync_n = 1'b0;
    logic sensor = 1'b0;
    logic walk_push = 1'b0;
    logic prog_sync = 1'b0;
    logic [1:0] time_param_sel = 2'b00;
    logic [3:0] time_value = 4'd0;
    logic expired = 1'b0;
    logic start_timer;
    logic [3:0] value;
    logic [2:0] main_lights, side_lights;
    logic walk_light;

    int vectors = 0;
    int errs = 0;
    logic [10:0] sb[$];

    typedef struct packed {
        logic sen;
        logic push;
        logic [10:0] e;
    } vec_t;

    always #5 clock = ~clock;

    traffic_light_controller dut (
        .clock(clock),
        .reset_sync_n(reset_sync_n),
        .sensor(sensor),
        .walk_push(walk_push),
        .prog_sync(prog_sync),
        .time_param_sel(time_param_sel),
        .time_value(time_value),
        .expired(expired),
        .start_timer(start_timer),
        .value(value),
        .main_lights(main_lights),
        .side_lights(side_lights),
        .walk_light(walk_light)
    );

    function automatic vec_t mk(input logic sen, input logic push, input logic [3:0] v,
                                input logic [2:0] m, input logic [2:0] s, input logic w);
        return {sen, push, v, m, s, w};
    endfunction

    function automatic logic [10:0] obs();
        return {value, main_lights, side_lights, walk_light};
    endfunction

    task automatic await_load(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (start_timer) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic fire();
        @(negedge clock);
        expired = 1'b1;
        @(negedge clock);
        expired = 1'b0;
    endtask

    task automatic prog(input logic [1:0] sel, input logic [3:0] v);
        @(negedge clock);
        prog_sync = 1'b1;
        time_param_sel = sel;
        time_value = v;
        @(negedge clock);
        prog_sync = 1'b0;
    endtask

    task automatic step(input vec_t t, output bit ok);
        sensor = t.sen;
        if (t.push) begin
            @(negedge clock);
            walk_push = 1'b1;
            @(negedge clock);
            walk_push = 1'b0;
        end
        sb.push_back(t.e);
        fire();
        await_load(ok);
    endtask

    task automatic test_reset();
        bit ok;
        logic [10:0] e;
        reset_sync_n = 1'b0;
        repeat (2) @(negedge clock);
        vectors++;
        if ({start_timer, obs()} !== {1'b0, 4'd6, RED, RED, 1'b0}) begin
            errs++;
            $display("FAIL reset_values: got start=%b %h want start=0 %h", start_timer, obs(), {4'd6, RED, RED, 1'b0});
        end
        reset_sync_n = 1'b1;
        sb.push_back({4'd6, GRN, RED, 1'b0});
        await_load(ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || obs() !== e) begin
            errs++;
            $display("FAIL first_load: got %h (start seen %b) want %h", obs(), ok, e);
        end
        @(negedge clock);
        vectors++;
        if (start_timer !== 1'b0) begin
            errs++;
            $display("FAIL start_one_cycle: got %b want 0", start_timer);
        end
    endtask

    task automatic test_extension();
        vec_t tbl[2];
        bit ok;
        logic [10:0] e;
        tbl = '{mk(1'b0, 1'b0, 4'd3, GRN, RED, 1'b0), mk(1'b0, 1'b0, 4'd3, GRN, RED, 1'b0)};
        foreach (tbl[i]) begin
            step(tbl[i], ok);
            e = sb.pop_front();
            vectors++;
            if (!ok || obs() !== e) begin
                errs++;
                $display("FAIL extension[%0d]: got %h (start seen %b) want %h", i, obs(), ok, e);
            end
        end
    endtask

    task automatic test_sensor_cycle();
        vec_t tbl[5];
        bit ok;
        logic [10:0] e;
        tbl = '{mk(1'b1, 1'b0, 4'd2, YEL, RED, 1'b0), mk(1'b1, 1'b0, 4'd6, RED, GRN, 1'b0),
                mk(1'b1, 1'b0, 4'd3, RED, GRN, 1'b0), mk(1'b0, 1'b0, 4'd2, RED, YEL, 1'b0),
                mk(1'b0, 1'b0, 4'd6, GRN, RED, 1'b0)};
        foreach (tbl[i]) begin
            step(tbl[i], ok);
            e = sb.pop_front();
            vectors++;
            if (!ok || obs() !== e) begin
                errs++;
                $display("FAIL sensor_cycle[%0d]: got %h (start seen %b) want %h", i, obs(), ok, e);
            end
        end
    endtask

    task automatic test_walk();
        vec_t tbl[10];
        bit ok;
        logic [10:0] e;
        tbl = '{mk(1'b1, 1'b0, 4'd2, YEL, RED, 1'b0), mk(1'b0, 1'b0, 4'd6, RED, GRN, 1'b0),
                mk(1'b0, 1'b1, 4'd2, RED, YEL, 1'b0), mk(1'b0, 1'b0, 4'd6, GRN, RED, 1'b0),
                mk(1'b0, 1'b0, 4'd2, YEL, RED, 1'b0), mk(1'b0, 1'b0, 4'd3, RED, RED, 1'b1),
                mk(1'b0, 1'b0, 4'd6, RED, GRN, 1'b0), mk(1'b0, 1'b0, 4'd2, RED, YEL, 1'b0),
                mk(1'b0, 1'b0, 4'd6, GRN, RED, 1'b0), mk(1'b0, 1'b0, 4'd3, GRN, RED, 1'b0)};
        foreach (tbl[i]) begin
            step(tbl[i], ok);
            e = sb.pop_front();
            vectors++;
            if (!ok || obs() !== e) begin
                errs++;
                $display("FAIL walk[%0d]: got %h (start seen %b) want %h", i, obs(), ok, e);
            end
        end
    endtask

    task automatic test_expired_mask();
        bit ok;
        int starts;
        logic [10:0] e;
        reset_sync_n = 1'b0;
        sensor = 1'b0;
        expired = 1'b1;
        repeat (2) @(negedge clock);
        reset_sync_n = 1'b1;
        sb.push_back({4'd6, GRN, RED, 1'b0});
        await_load(ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || obs() !== e) begin
            errs++;
            $display("FAIL mask_first_load: got %h (start seen %b) want %h", obs(), ok, e);
        end
        @(negedge clock);
        expired = 1'b0;
        starts = 0;
        repeat (6) begin
            @(negedge clock);
            if (start_timer) starts++;
        end
        vectors++;
        if (starts != 0 || obs() !== {4'd6, GRN, RED, 1'b0}) begin
            errs++;
            $display("FAIL mask_no_transition: got %0d loads, %h want 0 loads, %h", starts, obs(), {4'd6, GRN, RED, 1'b0});
        end
        step(mk(1'b0, 1'b0, 4'd3, GRN, RED, 1'b0), ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || obs() !== e) begin
            errs++;
            $display("FAIL mask_wait_expiry: got %h (start seen %b) want %h", obs(), ok, e);
        end
    endtask

    task automatic test_prog();
        vec_t tbl[7];
        bit ok;
        logic [10:0] e;
        prog(SEL_YEL, 4'd0);
        prog(SEL_BASE, 4'd9);
        vectors++;
        if ({start_timer, value} !== {1'b0, 4'd3}) begin
            errs++;
            $display("FAIL prog_mid_phase: got start=%b value=%0d want start=0 value=3", start_timer, value);
        end
        tbl = '{mk(1'b1, 1'b0, 4'd1, YEL, RED, 1'b0), mk(1'b0, 1'b0, 4'd9, RED, GRN, 1'b0),
                mk(1'b0, 1'b0, 4'd1, RED, YEL, 1'b0), mk(1'b0, 1'b0, 4'd9, GRN, RED, 1'b0),
                mk(1'b0, 1'b0, 4'd9, RED, GRN, 1'b0), mk(1'b0, 1'b0, 4'd5, RED, YEL, 1'b0),
                mk(1'b0, 1'b0, 4'd9, GRN, RED, 1'b0)};
        for (int i = 0; i < 4; i++) begin
            step(tbl[i], ok);
            e = sb.pop_front();
            vectors++;
            if (!ok || obs() !== e) begin
                errs++;
                $display("FAIL prog[%0d]: got %h (start seen %b) want %h", i, obs(), ok, e);
            end
        end
        sensor = 1'b1;
        sb.push_back({4'd1, YEL, RED, 1'b0});
        fire();
        prog_sync = 1'b1;
        time_param_sel = SEL_YEL;
        time_value = 4'd5;
        @(negedge clock);
        prog_sync = 1'b0;
        e = sb.pop_front();
        vectors++;
        if ({start_timer, obs()} !== {1'b1, e}) begin
            errs++;
            $display("FAIL prog_load_collision: got start=%b %h want start=1 %h", start_timer, obs(), e);
        end
        for (int i = 4; i < 7; i++) begin
            step(tbl[i], ok);
            e = sb.pop_front();
            vectors++;
            if (!ok || obs() !== e) begin
                errs++;
                $display("FAIL prog[%0d]: got %h (start seen %b) want %h", i, obs(), ok, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t tbl[3];
        bit ok;
        logic [10:0] e;
        tbl = '{mk(1'b1, 1'b0, 4'd5, YEL, RED, 1'b0), mk(1'b1, 1'b0, 4'd9, RED, GRN, 1'b0),
                mk(1'b1, 1'b0, 4'd3, RED, GRN, 1'b0)};
        foreach (tbl[i]) begin
            step(tbl[i], ok);
            e = sb.pop_front();
            vectors++;
            if (!ok || obs() !== e) begin
                errs++;
                $display("FAIL reset_mid_setup[%0d]: got %h (start seen %b) want %h", i, obs(), ok, e);
            end
        end
        @(negedge clock);
        reset_sync_n = 1'b0;
        expired = 1'b1;
        #1;
        vectors++;
        if ({start_timer, obs()} !== {1'b0, 4'd6, RED, RED, 1'b0}) begin
            errs++;
            $display("FAIL async_reset: got start=%b %h want start=0 %h", start_timer, obs(), {4'd6, RED, RED, 1'b0});
        end
        @(negedge clock);
        reset_sync_n = 1'b1;
        sensor = 1'b0;
        sb.push_back({4'd6, GRN, RED, 1'b0});
        await_load(ok);
        expired = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (!ok || obs() !== e) begin
            errs++;
            $display("FAIL reset_mid_reload: got %h (start seen %b) want %h", obs(), ok, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_extension();
        test_sensor_cycle();
        test_walk();
        test_expired_mask();
        test_prog();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
